// File: rtl/rename_in_buf_pkg.sv
// Shared types and helpers for the decode-to-rename input buffer.
package rename_in_agent_dec;

    localparam int unsigned DEF_DATA_W = 64;
    localparam int unsigned DEF_SEQ_W  = 8;

    typedef logic [DEF_DATA_W-1:0] uop_data_t;
    typedef logic [DEF_SEQ_W-1:0]  uop_seq_t;

    typedef struct packed {
        uop_data_t data;
        uop_seq_t  seq;
    } uop_entry_t;

    // True when mask is of the form 0..01..1 (all-zero included).
    function automatic logic is_prefix_mask(input logic [31:0] mask);
        logic [31:0] nxt;
        nxt = mask + 32'd1;
        return (mask & nxt) == 32'd0;
    endfunction

endpackage

// File: rtl/rename_in_buf_popcnt.sv
// Combinational population count of a W-bit vector.
module rename_in_buf_popcnt #(
    parameter int unsigned W     = 4,
    parameter int unsigned OUT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     bits_i,
    output logic [OUT_W-1:0] cnt_o
);

    // Sum the set bits.
    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_o = cnt_o + OUT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/rename_in_buf.sv
// Multi-lane in-order queue between decode and rename with sequence tagging,
// flush and sticky protocol-error reporting.
module rename_in_buf
    import rename_in_agent_dec::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ENQ_W  = 4,
    parameter int unsigned DEQ_W  = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SEQ_W  = DEF_SEQ_W,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1),
    parameter int unsigned ACC_W  = $clog2(DEQ_W + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic [ENQ_W-1:0]        in_valid_i,
    input  logic [ENQ_W*DATA_W-1:0] in_data_i,
    output logic                    in_ready_o,
    output logic [DEQ_W-1:0]        out_valid_o,
    output logic [DEQ_W*DATA_W-1:0] out_data_o,
    output logic [DEQ_W*SEQ_W-1:0]  out_seq_o,
    input  logic [ACC_W-1:0]        out_accept_i,
    output logic [CNT_W-1:0]        count_o,
    output logic                    err_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned ENQ_CW = $clog2(ENQ_W + 1);

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d, free_cnt;
    logic [SEQ_W-1:0]  seq_base_q;
    logic              err_q;

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];

    logic [ENQ_CW-1:0] n_enq;
    logic [ACC_W-1:0]  n_vis, n_acc;
    logic              mask_legal, enq_fire, enq_bad, acc_legal, acc_bad;

    rename_in_buf_popcnt #(
        .W     (ENQ_W),
        .OUT_W (ENQ_CW)
    ) u_popcnt_enq (
        .bits_i (in_valid_i),
        .cnt_o  (n_enq)
    );

    rename_in_buf_popcnt #(
        .W     (DEQ_W),
        .OUT_W (ACC_W)
    ) u_popcnt_vis (
        .bits_i (out_valid_o),
        .cnt_o  (n_vis)
    );

    // Ready looks only at registered occupancy; a same-cycle dequeue never helps.
    assign free_cnt   = CNT_W'(DEPTH) - count_q;
    assign in_ready_o = free_cnt >= CNT_W'(ENQ_W);

    // Enqueue / accept qualification and next occupancy.
    always_comb begin
        mask_legal = is_prefix_mask(32'(in_valid_i));
        enq_fire   = in_ready_o & (|in_valid_i) & mask_legal & ~flush_i;
        enq_bad    = in_ready_o & (|in_valid_i) & ~mask_legal & ~flush_i;
        acc_legal  = out_accept_i <= n_vis;
        acc_bad    = ~acc_legal & ~flush_i;
        n_acc      = acc_legal ? out_accept_i : '0;
        count_d    = count_q + (enq_fire ? CNT_W'(n_enq) : '0) - CNT_W'(n_acc);
    end

    // Pointer, occupancy, tag and error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_base_q <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_q | enq_bad | acc_bad;
            if (flush_i) begin
                // Tags are deliberately left running across a flush.
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (enq_fire) begin
                    wr_ptr_q   <= wr_ptr_q + PTR_W'(n_enq);
                    seq_base_q <= seq_base_q + SEQ_W'(n_enq);
                end
                rd_ptr_q <= rd_ptr_q + PTR_W'(n_acc);
                count_q  <= count_d;
            end
        end
    end

    // Payload storage; not reset, validity comes from count.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            for (int unsigned k = 0; k < ENQ_W; k++) begin
                if (in_valid_i[k]) begin
                    mem_data[wr_ptr_q + PTR_W'(k)] <= in_data_i[k*DATA_W +: DATA_W];
                    mem_seq[wr_ptr_q + PTR_W'(k)]  <= seq_base_q + SEQ_W'(k);
                end
            end
        end
    end

    for (genvar i = 0; i < DEQ_W; i++) begin : g_out
        assign out_valid_o[i]                  = count_q > CNT_W'(i);
        assign out_data_o[i*DATA_W +: DATA_W]  = mem_data[rd_ptr_q + PTR_W'(i)];
        assign out_seq_o[i*SEQ_W +: SEQ_W]     = mem_seq[rd_ptr_q + PTR_W'(i)];
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_rename_in_buf.sv
// Bench for rename_in_buf: vector table with constant occupancy/ready/error
// expectations, plus a scoreboard queue for lane payloads and tags.
module tb_rename_in_buf;

    localparam int DATA_W = 64;
    localparam int ENQ_W  = 4;
    localparam int DEQ_W  = 4;
    localparam int DEPTH  = 16;
    localparam int SEQ_W  = 8;
    localparam int CNT_W  = 5;
    localparam int ACC_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    flush = 1'b0;
    logic [ENQ_W-1:0]        in_valid = '0;
    logic [ENQ_W*DATA_W-1:0] in_data = '0;
    logic                    in_ready;
    logic [DEQ_W-1:0]        out_valid;
    logic [DEQ_W*DATA_W-1:0] out_data;
    logic [DEQ_W*SEQ_W-1:0]  out_seq;
    logic [ACC_W-1:0]        out_accept = '0;
    logic [CNT_W-1:0]        count;
    logic                    err;

    rename_in_buf #(
        .DATA_W (DATA_W),
        .ENQ_W  (ENQ_W),
        .DEQ_W  (DEQ_W),
        .DEPTH  (DEPTH),
        .SEQ_W  (SEQ_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_seq_o    (out_seq),
        .out_accept_i (out_accept),
        .count_o      (count),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } exp_t;

    typedef struct {
        logic [3:0] v;
        logic       fl;
        logic [2:0] acc;
        int         cnt;
        logic       rdy;
        logic       er;
    } vec_t;

    exp_t             sb_q[$];
    logic [SEQ_W-1:0] m_seq = '0;
    int               n_pass = 0;
    int               n_chk = 0;
    vec_t             vt[22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Compare presented lanes against the scoreboard head.
    task automatic check_lanes(input string tag);
        logic [DEQ_W-1:0] expv;
        expv = '0;
        for (int i = 0; i < DEQ_W; i++) expv[i] = (i < sb_q.size());
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(expv));
        for (int i = 0; i < DEQ_W && i < sb_q.size(); i++) begin
            chk($sformatf("%s_lane%0d_data", tag, i), out_data[i*DATA_W +: DATA_W], sb_q[i].data);
            chk($sformatf("%s_lane%0d_seq", tag, i), 64'(out_seq[i*SEQ_W +: SEQ_W]),
                64'(sb_q[i].seq));
        end
    endtask

    // One clock of stimulus; scoreboard updated from the bench's own view of occupancy.
    task automatic cycle(input logic [3:0] v, input logic fl, input logic [2:0] acc,
                         input string tag);
        int               sz;
        int               vis;
        logic             rdy_m;
        logic [4:0]       v5;
        logic             legal;
        logic [DATA_W-1:0] lane_d[ENQ_W];
        sz    = sb_q.size();
        vis   = (sz < DEQ_W) ? sz : DEQ_W;
        rdy_m = (DEPTH - sz) >= ENQ_W;
        v5    = {1'b0, v};
        legal = ((v5 & (v5 + 5'd1)) == 5'd0);
        for (int k = 0; k < ENQ_W; k++) begin
            lane_d[k] = {$urandom, $urandom};
            in_data[k*DATA_W +: DATA_W] = lane_d[k];
        end
        in_valid   = v;
        flush      = fl;
        out_accept = acc;
        @(posedge clk);
        #1;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (int'(acc) <= vis) repeat (int'(acc)) void'(sb_q.pop_front());
            if (rdy_m && v != 4'd0 && legal) begin
                for (int k = 0; k < ENQ_W; k++) begin
                    if (v[k]) begin
                        sb_q.push_back('{data: lane_d[k], seq: m_seq});
                        m_seq++;
                    end
                end
            end
        end
        in_valid   = '0;
        flush      = 1'b0;
        out_accept = '0;
        check_lanes(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        //          valid  flush acc  count ready err
        vt[0]  = '{4'hF, 1'b0, 3'd0,  4, 1'b1, 1'b0};
        vt[1]  = '{4'hF, 1'b0, 3'd0,  8, 1'b1, 1'b0};
        vt[2]  = '{4'hF, 1'b0, 3'd0, 12, 1'b1, 1'b0};
        vt[3]  = '{4'hF, 1'b0, 3'd0, 16, 1'b0, 1'b0};
        vt[4]  = '{4'hF, 1'b0, 3'd0, 16, 1'b0, 1'b0};
        vt[5]  = '{4'hF, 1'b0, 3'd0, 16, 1'b0, 1'b0};
        vt[6]  = '{4'h0, 1'b0, 3'd4, 12, 1'b1, 1'b0};
        vt[7]  = '{4'h1, 1'b0, 3'd0, 13, 1'b0, 1'b0};
        vt[8]  = '{4'hF, 1'b0, 3'd0, 13, 1'b0, 1'b0};
        vt[9]  = '{4'h0, 1'b0, 3'd4,  9, 1'b1, 1'b0};
        vt[10] = '{4'hF, 1'b1, 3'd2,  0, 1'b1, 1'b0};
        vt[11] = '{4'h3, 1'b0, 3'd0,  2, 1'b1, 1'b0};
        vt[12] = '{4'hF, 1'b0, 3'd2,  4, 1'b1, 1'b0};
        vt[13] = '{4'hF, 1'b0, 3'd4,  4, 1'b1, 1'b0};
        vt[14] = '{4'hF, 1'b0, 3'd4,  4, 1'b1, 1'b0};
        vt[15] = '{4'h3, 1'b0, 3'd0,  6, 1'b1, 1'b0};
        vt[16] = '{4'h3, 1'b0, 3'd3,  5, 1'b1, 1'b0};
        vt[17] = '{4'h5, 1'b0, 3'd0,  5, 1'b1, 1'b1};
        vt[18] = '{4'h1, 1'b0, 3'd1,  5, 1'b1, 1'b1};
        vt[19] = '{4'h0, 1'b0, 3'd2,  3, 1'b1, 1'b1};
        vt[20] = '{4'h0, 1'b0, 3'd1,  2, 1'b1, 1'b1};
        vt[21] = '{4'h0, 1'b0, 3'd3,  2, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            cycle(vt[i].v, vt[i].fl, vt[i].acc, tag);
            chk({tag, "_count"}, 64'(count), 64'(vt[i].cnt));
            chk({tag, "_in_ready"}, 64'(in_ready), 64'(vt[i].rdy));
            chk({tag, "_err"}, 64'(err), 64'(vt[i].er));
            if (i == 0) chk("first_group_seqs", 64'(out_seq), 64'h0302_0100);
            if (i == 11) chk("post_flush_seq0", 64'(out_seq[SEQ_W-1:0]), 64'd17);
        end

        // Fresh reset, then an over-accept must flag an error and dequeue nothing.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_seq = '0;
        check_reset_state("reset2");
        rst_n = 1'b1;
        cycle(4'h3, 1'b0, 3'd0, "pre_overacc");
        chk("pre_overacc_count", 64'(count), 64'd2);
        cycle(4'h0, 1'b0, 3'd3, "overacc");
        chk("overacc_count", 64'(count), 64'd2);
        chk("overacc_err", 64'(err), 64'd1);

        // Asynchronous reset between clock edges while traffic is being offered.
        in_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        in_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
